// File: rtl/display_pkg.sv
// Shared display timing constants and derived-constant helpers for the scanout and HDMI paths.
package display_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_BPP      = 8;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned ppw(input int unsigned bpp);
    return 32 / bpp;
  endfunction

  function automatic int unsigned line_stride(input int unsigned h_act, input int unsigned bpp);
    return (h_act * bpp) / 8;
  endfunction

  // One spare code so the exclusive upper sync bound always fits the counter width.
  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster position counters with active-area, sync and frame-origin decode.
module video_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned HW       = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int unsigned VW       = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic          active_c,
  output logic          hsync_c,
  output logic          vsync_c,
  output logic          first_c
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [VW-1:0] v_cnt;

  // Disabled scanout parks the raster at the frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hsync_c  = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vsync_c  = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    first_c  = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/display_scanout.sv
// Framebuffer scanout: raster position -> word fetch (stage 1) -> unpacked pixel and syncs (stage 2).
module display_scanout
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned BPP      = DEF_BPP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [31:0]    fb_base,
  output logic [31:0]    displayAddr,
  input  logic [31:0]    displayData,
  output logic [BPP-1:0] pixel,
  output logic           de,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start
);

  localparam int unsigned PPW = ppw(BPP);
  localparam int unsigned HW  = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VW  = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  logic [HW-1:0]  h_cnt;
  logic           active_c, hsync_c, vsync_c, first_c;
  logic           fetch_c;
  logic [HW-1:0]  sel_c;
  logic [31:0]    cur_addr_c;
  logic [31:0]    src_word_c;
  logic [BPP-1:0] pix_c;
  logic [31:0]    word_addr;
  logic [31:0]    word_q;
  logic           s1_active, s1_hs, s1_vs, s1_first, s1_fetch;
  logic [HW-1:0]  s1_sel;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .h_cnt    (h_cnt),
    .active_c (active_c),
    .hsync_c  (hsync_c),
    .vsync_c  (vsync_c),
    .first_c  (first_c)
  );

  // Frame origin re-latches the base so a mid-frame fb_base change waits for the next frame.
  always_comb begin
    sel_c      = HW'(32'(h_cnt) % PPW);
    fetch_c    = en && active_c && (sel_c == '0);
    cur_addr_c = first_c ? (fb_base & 32'hFFFF_FFFC) : word_addr;
    src_word_c = s1_fetch ? displayData : word_q;
    pix_c      = BPP'(src_word_c >> (32'(s1_sel) * BPP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      displayAddr <= '0;
      word_addr   <= '0;
      s1_active   <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_first    <= 1'b0;
      s1_fetch    <= 1'b0;
      s1_sel      <= '0;
    end else begin
      s1_active <= en && active_c;
      s1_hs     <= en && hsync_c;
      s1_vs     <= en && vsync_c;
      s1_first  <= en && first_c;
      s1_fetch  <= fetch_c;
      s1_sel    <= sel_c;
      if (fetch_c) begin
        displayAddr <= cur_addr_c;
        word_addr   <= cur_addr_c + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      word_q      <= '0;
    end else if (!en) begin
      de          <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      de          <= s1_active;
      pixel       <= s1_active ? pix_c : '0;
      frame_start <= s1_first;
      hsync       <= s1_hs ? HS_POL : ~HS_POL;
      vsync       <= s1_vs ? VS_POL : ~VS_POL;
      if (s1_fetch) word_q <= displayData;
    end
  end

endmodule
